hazard_stall_controller: RTL and testbench

//  Pipeline control that acts on hazards flagged by the forwarding unit and execute stage.
//  - Load-use busy -> PC/IF-ID hold plus ID-EX bubble.
//  - Taken branch/jump -> IF-ID and ID-EX flush.
//  - Data-memory wait -> whole-pipe freeze.

---
 rtl/hazard_stall_controller_if.sv | 32 +++
 rtl/hazard_stall_controller.sv | 111 +++++++++++
 tb/tb_hazard_stall_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// Hazard/control bundle between the pipeline hazard sources and the stall controller.
// master: hazard sources (forwarding unit, EX stage, data memory) that consume the stage controls.
// slave : the stall controller itself.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             busy;
  logic             branch_taken;
  logic             jump;
  logic             mem_wait;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] freeze_count;

  modport master (
    output busy, branch_taken, jump, mem_wait,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
    input  stall_count, flush_count, freeze_count
  );

  modport slave (
    input  busy, branch_taken, jump, mem_wait,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
    output stall_count, flush_count, freeze_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard stall/flush controller.
// Mealy control outputs: a memory wait freezes the whole pipe, a redirect flushes IF/ID and
// ID/EX, a load-use hazard holds PC/IF-ID and bubbles ID/EX. Multi-cycle stalls/flushes are
// tracked by a small state machine; saturating counters record hazard cycles for debug.
module hazard_stall_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_W             = 16
) (
  input  logic                     clk,
  input  logic                     reset2,
  hazard_stall_controller_if.slave bus
);

  localparam int MAX_CYCLES = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_q, flush_q, freeze_q;
  logic             redirect;
  logic             do_freeze, do_flush, do_stall;

  assign redirect = bus.branch_taken | bus.jump;

  // Classify this cycle by priority: freeze > flush (redirect or ongoing) > stall > normal.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    do_freeze = 1'b0;
    do_flush  = 1'b0;
    do_stall  = 1'b0;
    if (bus.mem_wait) begin
      do_freeze = 1'b1;
    end else if (redirect || state == FLUSH) begin
      do_flush = 1'b1;
    end else if (bus.busy || state == STALL) begin
      do_stall = 1'b1;
    end
  end

  // Stage controls; all forced low while reset is asserted.
  assign bus.pc_en      = reset2 & ~do_freeze & ~do_stall;
  assign bus.ifid_en    = reset2 & ~do_freeze & ~do_stall;
  assign bus.idex_en    = reset2 & ~do_freeze;
  assign bus.exmem_en   = reset2 & ~do_freeze;
  assign bus.ifid_flush = reset2 & do_flush;
  assign bus.idex_flush = reset2 & (do_flush | do_stall);

  // Next state: freeze holds; a redirect (re)starts FLUSH from any state; cnt counts down extra cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (do_freeze) begin
      state_nxt = state;
      cnt_nxt   = cnt;
    end else if (redirect) begin
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = CW'(FLUSH_CYCLES - 1);
      end else begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end else if (state == FLUSH || state == STALL) begin
      if (cnt <= CW'(1)) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CW'(1);
      end
    end else if (bus.busy) begin
      if (LOAD_STALL_CYCLES > 1) begin
        state_nxt = STALL;
        cnt_nxt   = CW'(LOAD_STALL_CYCLES - 1);
      end else begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end else begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end
  end

  // State register and saturating hazard-cycle counters; exactly one counter moves per hazard cycle.
  always_ff @(posedge clk or negedge reset2) begin
    if (!reset2) begin
      state    <= RUN;
      cnt      <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (do_stall && stall_q != '1)   stall_q  <= stall_q + CNT_W'(1);
      if (do_flush && flush_q != '1)   flush_q  <= flush_q + CNT_W'(1);
      if (do_freeze && freeze_q != '1) freeze_q <= freeze_q + CNT_W'(1);
    end
  end

  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;
  assign bus.freeze_count = freeze_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller.
// dut_a: default parameters (1-cycle load stall, 2-cycle flush, 16-bit counters).
// dut_b: 2-cycle load stall, 4-bit counters, used for STALL-state and saturation cases.
// Control vectors are packed {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  logic reset2 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_stall_controller_if #(.CNT_W(16)) bus_a ();
  hazard_stall_controller_if #(.CNT_W(4))  bus_b ();

  hazard_stall_controller #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset2(reset2), .bus(bus_a)
  );
  hazard_stall_controller #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset2(reset2), .bus(bus_b)
  );

  localparam logic [5:0] NORMAL = 6'b111100;
  localparam logic [5:0] STALLV = 6'b001101;
  localparam logic [5:0] FLUSHV = 6'b111111;
  localparam logic [5:0] ZERO   = 6'b000000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, bus_a.pc_en, bus_a.ifid_en, bus_a.idex_en, bus_a.exmem_en,
                bus_a.ifid_flush, bus_a.idex_flush}, {26'd0, exp});
  endtask

  task automatic check_b(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en,
                bus_b.ifid_flush, bus_b.idex_flush}, {26'd0, exp});
  endtask

  task automatic check_cnt_a(input string tag, input int st, input int fl, input int fr);
    check({tag, "_stall"},  {16'd0, bus_a.stall_count},  st);
    check({tag, "_flush"},  {16'd0, bus_a.flush_count},  fl);
    check({tag, "_freeze"}, {16'd0, bus_a.freeze_count}, fr);
  endtask

  task automatic check_cnt_b(input string tag, input int st, input int fl, input int fr);
    check({tag, "_stall"},  {28'd0, bus_b.stall_count},  st);
    check({tag, "_flush"},  {28'd0, bus_b.flush_count},  fl);
    check({tag, "_freeze"}, {28'd0, bus_b.freeze_count}, fr);
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.busy = 1'b0; bus_a.branch_taken = 1'b0; bus_a.jump = 1'b0; bus_a.mem_wait = 1'b0;
    bus_b.busy = 1'b0; bus_b.branch_taken = 1'b0; bus_b.jump = 1'b0; bus_b.mem_wait = 1'b0;

    // Reset held: all controls low, counters clear.
    @(negedge clk);
    check_a("rst_out_a", ZERO);
    check_b("rst_out_b", ZERO);
    check_cnt_a("rst_a", 0, 0, 0);
    cyc();
    reset2 = 1'b1;

    // 1: idle after reset for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_a("idle_out", NORMAL);
      cyc();
    end
    check_cnt_a("idle_a", 0, 0, 0);
    check_cnt_b("idle_b", 0, 0, 0);

    // 2: single-cycle load-use stall.
    bus_a.busy = 1'b1;
    @(negedge clk); check_a("busy_c0", STALLV);
    cyc(); bus_a.busy = 1'b0;
    @(negedge clk); check_a("busy_c1", NORMAL);
    check_cnt_a("busy", 1, 0, 0);
    cyc();

    // 3: taken branch flushes two cycles.
    bus_a.branch_taken = 1'b1;
    @(negedge clk); check_a("br_c0", FLUSHV);
    cyc(); bus_a.branch_taken = 1'b0;
    @(negedge clk); check_a("br_c1", FLUSHV);
    cyc();
    @(negedge clk); check_a("br_c2", NORMAL);
    check_cnt_a("br", 1, 2, 0);
    cyc();

    // 4: busy and jump together: redirect wins, no stall counted.
    bus_a.busy = 1'b1; bus_a.jump = 1'b1;
    @(negedge clk); check_a("bj_c0", FLUSHV);
    cyc(); bus_a.busy = 1'b0; bus_a.jump = 1'b0;
    @(negedge clk); check_a("bj_c1", FLUSHV);
    cyc();
    @(negedge clk); check_a("bj_c2", NORMAL);
    check_cnt_a("bj", 1, 4, 0);
    cyc();

    // 5: branch then 3-cycle memory freeze mid-flush, flush resumes for its last cycle.
    bus_a.branch_taken = 1'b1;
    @(negedge clk); check_a("fz_c0", FLUSHV);
    cyc(); bus_a.branch_taken = 1'b0; bus_a.mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check_a("fz_frozen", ZERO);
      cyc();
    end
    bus_a.mem_wait = 1'b0;
    @(negedge clk); check_a("fz_resume", FLUSHV);
    cyc();
    @(negedge clk); check_a("fz_done", NORMAL);
    check_cnt_a("fz", 1, 6, 3);
    cyc();

    // dut_b: 2-cycle stall with a freeze in the middle.
    bus_b.busy = 1'b1;
    @(negedge clk); check_b("sb_c0", STALLV);
    cyc(); bus_b.busy = 1'b0; bus_b.mem_wait = 1'b1;
    @(negedge clk); check_b("sb_frozen", ZERO);
    cyc(); bus_b.mem_wait = 1'b0;
    @(negedge clk); check_b("sb_c1", STALLV);
    cyc();
    @(negedge clk); check_b("sb_done", NORMAL);
    check_cnt_b("sb", 2, 0, 1);
    cyc();

    // dut_b: jump aborts an ongoing stall.
    bus_b.busy = 1'b1;
    @(negedge clk); check_b("ab_c0", STALLV);
    cyc(); bus_b.busy = 1'b0; bus_b.jump = 1'b1;
    @(negedge clk); check_b("ab_c1", FLUSHV);
    cyc(); bus_b.jump = 1'b0;
    @(negedge clk); check_b("ab_c2", FLUSHV);
    cyc();
    @(negedge clk); check_b("ab_done", NORMAL);
    check_cnt_b("ab", 3, 2, 1);
    cyc();

    // 6: busy held 20 cycles on 4-bit counters: stall_count saturates at 15.
    bus_b.busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); check_b("hold_out", STALLV);
      cyc();
    end
    bus_b.busy = 1'b0;
    check_cnt_b("sat", 15, 2, 1);

    // 6: reset asserted mid-flush takes effect at once; normal after release.
    bus_a.branch_taken = 1'b1;
    @(negedge clk); check_a("rf_c0", FLUSHV);
    cyc(); bus_a.branch_taken = 1'b0;
    reset2 = 1'b0;
    #1;
    check_a("rf_in_reset", ZERO);
    check_cnt_a("rf_in_reset", 0, 0, 0);
    cyc();
    reset2 = 1'b1;
    @(negedge clk); check_a("rf_released", NORMAL);
    cyc();
    @(negedge clk); check_a("rf_run", NORMAL);
    check_cnt_a("rf_run", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
